// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, round constants, word/state types and the
// key-schedule FSM state enum. Used by the key expansion and sub-bytes logic.
package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] state_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    // Forward AES S-box, indexed by the input byte.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Round constants, indexed by round number 1..10. Entry 0 and 11..15 are
    // padding so a 4-bit index never falls outside the table.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/aes_key_expansion_if.sv
// Handshake/bus bundle between the key schedule and its user.
// key_ready exists only when AES_KEY_EXP_BACKPRESSURE_EN is defined.
interface aes_key_expansion_if;
    import aes_pkg::*;

    logic        start;
    state_t      cipher_key;
`ifdef AES_KEY_EXP_BACKPRESSURE_EN
    logic        key_ready;
`endif
    state_t      round_key;
    logic [3:0]  round_idx;
    logic        key_valid;
    logic        busy;
    logic        done;

`ifdef AES_KEY_EXP_BACKPRESSURE_EN
    modport master (output start, cipher_key, key_ready,
                    input  round_key, round_idx, key_valid, busy, done);
    modport slave  (input  start, cipher_key, key_ready,
                    output round_key, round_idx, key_valid, busy, done);
`else
    modport master (output start, cipher_key,
                    input  round_key, round_idx, key_valid, busy, done);
    modport slave  (input  start, cipher_key,
                    output round_key, round_idx, key_valid, busy, done);
`endif

endinterface

// File: rtl/aes_sub_word.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word.
// Purely combinational; shared with the cipher's sub-bytes stage.
module aes_sub_word
    import aes_pkg::*;
(
    input  word_t i_word,
    output word_t o_word
);

    // Four independent byte lookups.
    always_comb begin
        o_word = '0;
        for (int i = 0; i < 4; i++) begin
            o_word[8*i +: 8] = sbox(i_word[8*i +: 8]);
        end
    end

endmodule

// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key schedule: emits round keys 0..NUM_ROUNDS, one per
// accepted cycle, computing each key from the previous one.
// Optional feature macro: AES_KEY_EXP_BACKPRESSURE_EN (adds key_ready stall).
module aes_key_expansion
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
)(
    input logic              clk,
    input logic              rst_n,
    aes_key_expansion_if.slave bus
);

    state_e     r_state;
    state_e     w_nextState;
    state_t     r_roundKey;
    logic [3:0] r_roundIdx;
    logic       r_done;

    logic       w_keyReady;
    logic       w_accept;
    logic       w_last;
    word_t      w_rotWord;
    word_t      w_subWord;
    word_t      w_temp;
    word_t      w_w0;
    word_t      w_w1;
    word_t      w_w2;
    word_t      w_w3;
    state_t     w_nextKey;

`ifdef AES_KEY_EXP_BACKPRESSURE_EN
    assign w_keyReady = bus.key_ready;
`else
    assign w_keyReady = 1'b1;
`endif

    // key_valid is exactly "in RUN", so an accept only needs the ready side.
    assign w_accept = (r_state == RUN) && w_keyReady;
    assign w_last   = (r_roundIdx == 4'(NUM_ROUNDS));

    // Next round key: RotWord, SubWord and Rcon on the last word, then a
    // chained XOR across the four words.
    assign w_rotWord = {r_roundKey[23:0], r_roundKey[31:24]};

    aes_sub_word u_subWord (
        .i_word (w_rotWord),
        .o_word (w_subWord)
    );

    assign w_temp    = w_subWord ^ {RCON[r_roundIdx + 4'd1], 24'h0};
    assign w_w0      = r_roundKey[127:96] ^ w_temp;
    assign w_w1      = r_roundKey[95:64]  ^ w_w0;
    assign w_w2      = r_roundKey[63:32]  ^ w_w1;
    assign w_w3      = r_roundKey[31:0]   ^ w_w2;
    assign w_nextKey = {w_w0, w_w1, w_w2, w_w3};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: start leaves IDLE, accepting the final key returns.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (bus.start)           w_nextState = RUN;
            RUN:  if (w_accept && w_last)  w_nextState = IDLE;
            default:                       w_nextState = IDLE;
        endcase
    end

    // Key/index datapath and the one-cycle done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_roundKey <= '0;
            r_roundIdx <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (bus.start) begin
                    r_roundKey <= bus.cipher_key;
                    r_roundIdx <= '0;
                end
            end else if (w_accept) begin
                if (w_last) begin
                    r_done <= 1'b1;
                end else begin
                    r_roundKey <= w_nextKey;
                    r_roundIdx <= r_roundIdx + 4'd1;
                end
            end
        end
    end

    assign bus.round_key = r_roundKey;
    assign bus.round_idx = r_roundIdx;
    assign bus.key_valid = (r_state == RUN);
    assign bus.busy      = (r_state == RUN);
    assign bus.done      = r_done;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Self-checking bench for aes_key_expansion. The reference schedule is built
// from the word-recurrence form of the key expansion, with the S-box derived
// from GF(2^8) inversion plus the affine map. Stall tests only run when
// AES_KEY_EXP_BACKPRESSURE_EN is defined.
module tb_aes_key_expansion;

    localparam int NR = 10;

    typedef struct {
        logic [127:0] key;
        logic [127:0] idx1;
        logic [127:0] idx10;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [127:0] modelKeys [0:NR];
    logic [127:0] seenKeys  [0:NR];
    vec_t         vecs [2];

    always #5 clk = ~clk;

    aes_key_expansion_if bus ();

    aes_key_expansion #(.NUM_ROUNDS(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        if (a == 8'h00) return 8'h00;
        for (int b = 1; b < 256; b++) begin
            if (gmul(a, 8'(b)) == 8'h01) return 8'(b);
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] sboxModel(input logic [7:0] a);
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] r;
        x = ginv(a);
        y = x;
        r = x;
        for (int i = 0; i < 4; i++) begin
            y = {y[6:0], y[7]};
            r ^= y;
        end
        return r ^ 8'h63;
    endfunction

    function automatic logic [7:0] rconModel(input int i);
        logic [7:0] r = 8'h01;
        for (int j = 1; j < i; j++) r = xtime(r);
        return r;
    endfunction

    function automatic logic [31:0] subWordModel(input logic [31:0] w);
        return {sboxModel(w[31:24]), sboxModel(w[23:16]),
                sboxModel(w[15:8]),  sboxModel(w[7:0])};
    endfunction

    // Full expansion as 44 words, then regrouped into round keys.
    task automatic buildModel(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] temp;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0)
                temp = subWordModel({temp[23:0], temp[31:24]}) ^ {rconModel(i/4), 24'h0};
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r <= NR; r++)
            modelKeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, " round_key"}, bus.round_key, 128'h0);
        checkOutput({tag, " round_idx"}, 128'(bus.round_idx), 128'h0);
        checkOutput({tag, " key_valid"}, 128'(bus.key_valid), 128'h0);
        checkOutput({tag, " busy"},      128'(bus.busy), 128'h0);
        checkOutput({tag, " done"},      128'(bus.done), 128'h0);
    endtask

    task automatic applyStimulus(input logic [127:0] key);
        bus.start      = 1'b1;
        bus.cipher_key = key;
        @(negedge clk);
        bus.start      = 1'b0;
    endtask

    // mode: 0 plain, 1 extra start at idx5, 2 reset at idx7,
    //       3 restart in the done cycle with nextKey, 4 stall 3 cycles at idx4
    task automatic runSchedule(input logic [127:0] key, input int mode,
                               input logic [127:0] nextKey, input bit skipStart);
        buildModel(key);
        if (!skipStart) applyStimulus(key);
        for (int k = 0; k <= NR; k++) begin
            seenKeys[k] = bus.round_key;
            checkOutput($sformatf("valid k%0d", k), 128'(bus.key_valid), 128'h1);
            checkOutput($sformatf("busy k%0d", k),  128'(bus.busy), 128'h1);
            checkOutput($sformatf("done k%0d", k),  128'(bus.done), 128'h0);
            checkOutput($sformatf("idx k%0d", k),   128'(bus.round_idx), 128'(k));
            checkOutput($sformatf("key k%0d", k),   bus.round_key, modelKeys[k]);
            if (mode == 2 && k == 7) begin
                rst_n = 1'b0;
                #1;
                checkIdleZero("async reset");
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                checkIdleZero("after reset");
                return;
            end
`ifdef AES_KEY_EXP_BACKPRESSURE_EN
            if (mode == 4 && k == 4) begin
                bus.key_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("stall idx",   128'(bus.round_idx), 128'd4);
                    checkOutput("stall key",   bus.round_key, modelKeys[4]);
                    checkOutput("stall valid", 128'(bus.key_valid), 128'h1);
                    checkOutput("stall done",  128'(bus.done), 128'h0);
                end
                bus.key_ready = 1'b1;
            end
`endif
            if (mode == 1 && k == 5) begin
                bus.start      = 1'b1;
                bus.cipher_key = ~key;
            end
            @(negedge clk);
            bus.start = 1'b0;
        end
        checkOutput("done pulse",  128'(bus.done), 128'h1);
        checkOutput("done valid",  128'(bus.key_valid), 128'h0);
        checkOutput("done busy",   128'(bus.busy), 128'h0);
        checkOutput("done idx",    128'(bus.round_idx), 128'(NR));
        checkOutput("done key",    bus.round_key, modelKeys[NR]);
        if (mode == 3) begin
            applyStimulus(nextKey);
            return;
        end
        @(negedge clk);
        checkOutput("post done",  128'(bus.done), 128'h0);
        checkOutput("post valid", 128'(bus.key_valid), 128'h0);
        checkOutput("post key",   bus.round_key, modelKeys[NR]);
        checkOutput("post idx",   128'(bus.round_idx), 128'(NR));
    endtask

    initial begin
        logic [127:0] rk;

        vecs[0] = '{key:   128'h2b7e151628aed2a6abf7158809cf4f3c,
                    idx1:  128'ha0fafe1788542cb123a339392a6c7605,
                    idx10: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{key:   128'h0,
                    idx1:  128'h62636363626363636263636362636363,
                    idx10: 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

        bus.start      = 1'b0;
        bus.cipher_key = '0;
`ifdef AES_KEY_EXP_BACKPRESSURE_EN
        bus.key_ready  = 1'b1;
`endif
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkIdleZero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        checkIdleZero("idle");

        for (int v = 0; v < 2; v++) begin
            runSchedule(vecs[v].key, 0, '0, 1'b0);
            checkOutput($sformatf("vec%0d idx0", v),  seenKeys[0],  vecs[v].key);
            checkOutput($sformatf("vec%0d idx1", v),  seenKeys[1],  vecs[v].idx1);
            checkOutput($sformatf("vec%0d idx10", v), seenKeys[NR], vecs[v].idx10);
        end

        for (int r = 0; r < 4; r++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            runSchedule(rk, 0, '0, 1'b0);
        end

        runSchedule(vecs[0].key, 1, '0, 1'b0);
        checkOutput("ignored start idx10", seenKeys[NR], vecs[0].idx10);

        runSchedule(vecs[0].key, 3, vecs[1].key, 1'b0);
        runSchedule(vecs[1].key, 0, '0, 1'b1);
        checkOutput("back-to-back idx10", seenKeys[NR], vecs[1].idx10);

        rk = {$urandom, $urandom, $urandom, $urandom};
        runSchedule(rk, 2, '0, 1'b0);
        runSchedule(vecs[0].key, 0, '0, 1'b0);
        checkOutput("restart idx10", seenKeys[NR], vecs[0].idx10);

`ifdef AES_KEY_EXP_BACKPRESSURE_EN
        runSchedule(vecs[0].key, 4, '0, 1'b0);
        checkOutput("stall idx1",  seenKeys[1],  vecs[0].idx1);
        checkOutput("stall idx10", seenKeys[NR], vecs[0].idx10);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_key_expansion.md
# aes_key_expansion

Iterative AES-128 key schedule generator. It accepts a 128-bit cipher key and emits round keys 0..NUM_ROUNDS, one per accepted cycle, on a registered output. That output drives the round_key input of the add-round-key stage directly. One new round key is computed per cycle from the previous one, so no 11-entry key table is stored.

## Interface
- NUM_ROUNDS, default 10: index of the last round key emitted. Legal range is 1..10; values below 10 exist only for truncated-schedule testing.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a schedule. Sampled only in IDLE.
- cipher_key  input  128  key, sampled on the cycle start is accepted. Word w0 = [127:96], w3 = [31:0].
- key_ready  input  1  downstream accepts the current key. Present only with the backpressure macro (see Configuration).
- round_key  output  128  current round key, registered.
- round_idx  output  4  index of round_key, 0..NUM_ROUNDS.
- key_valid  output  1  round_key/round_idx are valid.
- busy  output  1  schedule in progress (state RUN).
- done  output  1  one-cycle pulse after the final key is accepted.

## Operation
- States:
  - IDLE: start=1 loads round_key=cipher_key and round_idx=0, sets key_valid=1, moves to RUN. Otherwise outputs hold.
  - RUN: a key is accepted when key_valid & key_ready.
    - Accept with round_idx<NUM_ROUNDS: round_key<=next(round_key), round_idx++.
    - Accept with round_idx==NUM_ROUNDS: key_valid<=0, done<=1, go to IDLE.
    - No accept: all outputs hold.
- Next-key function, with words w0..w3 of the current key:
  - t = SubWord(RotWord(w3)) ^ {Rcon[round_idx+1], 24'h0}.
  - RotWord({b0,b1,b2,b3}) = {b1,b2,b3,b0}.
  - SubWord applies the AES S-box to each byte.
  - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'. All XORs are 32-bit; there is no carry.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- start in RUN is ignored; no queuing. cipher_key changes in RUN have no effect.
- start in the same cycle done is high is legal: the FSM is in IDLE then, so the new schedule starts.
- After a schedule ends, round_key and round_idx keep their last values. Only key_valid drops.

## Timing
- Reset (async assert, sync deassert by the system): round_key=0, round_idx=0, key_valid=0, busy=0, done=0, state=IDLE.
- Reset mid-schedule aborts immediately to the reset values. No partial done is emitted.
- Latency:
  - start accepted at edge N: key 0 is valid after edge N.
  - Without stalls, key k is valid in cycle N+1+k.
  - done is high in cycle N+NUM_ROUNDS+2.
  - A full schedule takes NUM_ROUNDS+1 cycles of key_valid.
- busy is high exactly while key_valid is high. done and key_valid are never high together.
- next() is a single combinational cycle: 4 S-box lookups plus XOR chain, register to register.

## Configuration
- AES_KEY_EXP_BACKPRESSURE_EN:
  - Defined: the key_ready port exists. Keys advance only on key_valid & key_ready. key_valid may not drop while held.
  - Undefined: key_ready is absent and treated as constant 1, so keys advance every cycle.

## Structure
- Shared package aes_pkg holds:
  - the 256-entry S-box constant;
  - the Rcon[1..10] constant;
  - typedefs for the 32-bit word and the 128-bit state;
  - the FSM state enum (IDLE, RUN).
- Sub-module aes_sub_word: combinational, 32 bits in and 32 bits out, four S-box lookups. It is reusable by the sub-bytes stage.

## Test plan
- FIPS-197 vector: key 2b7e151628aed2a6abf7158809cf4f3c -> idx0 = the key, idx1 = a0fafe1788542cb123a339392a6c7605, idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6. done fires 12 cycles after start.
- All-zero key -> idx1 = 62636363626363636263636362636363, idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure (macro defined): drop key_ready for 3 cycles at idx4 -> round_key and idx4 held stable. The sequence is otherwise identical to the FIPS vector, and done is delayed by 3 cycles.
- start pulsed at idx5 with a different cipher_key -> ignored; the schedule completes with the original key.
- start asserted in the done cycle -> a new schedule begins; key 0 appears in the next cycle with no idle gap.
- rst_n asserted at idx7 -> all outputs go to 0 immediately. A later start restarts cleanly from idx0.
